// File: rtl/grant_dispatcher.sv
// grant_dispatcher: turns the encoded winner from a rotating priority encoder
// into a registered one-hot grant. It holds each tenure until the resource
// signals done, the owner withdraws its request, or MAX_HOLD cycles have
// elapsed. On each tenure end it advances the rotation start fed back to the
// encoder.
module grant_dispatcher #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] grant_in,
  input  logic       grant_valid,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] ack,
  output logic [2:0] owner,
  output logic       busy,
  output logic [2:0] priority_out,
  output logic       timeout
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_HOLD - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    owner_r, owner_s;
  logic [7:0]    ack_r, ack_s;
  logic          busy_r, busy_s;
  logic [2:0]    prio_r, prio_s;
  logic          timeout_r, timeout_s;
  logic          end_early_s;
  logic          expire_s;

  // One-hot decode of a requester index.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

  // Next-state and next-output computation; outputs are registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    owner_s     = owner_r;
    ack_s       = ack_r;
    busy_s      = busy_r;
    prio_s      = prio_r;
    timeout_s   = 1'b0;
    // A done pulse or a withdrawn request takes precedence over expiry, so a
    // coinciding expiry is treated as a normal exit without a timeout pulse.
    end_early_s = done || !req[owner_r];
    expire_s    = (cnt_r == LAST_CNT);
    case (state_r)
      ST_IDLE: begin
        if (grant_valid && req[grant_in]) begin
          state_s = ST_HOLD;
          owner_s = grant_in;
          cnt_s   = {CW{1'b0}};
          ack_s   = onehot8(grant_in);
          busy_s  = 1'b1;
        end else begin
          ack_s  = 8'd0;
          busy_s = 1'b0;
        end
      end
      ST_HOLD: begin
        if (end_early_s || expire_s) begin
          state_s   = ST_RELEASE;
          ack_s     = 8'd0;
          busy_s    = 1'b0;
          prio_s    = owner_r + 3'd1;
          timeout_s = expire_s && !end_early_s;
        end else begin
          // Increment stops at exit, so the counter never wraps in HOLD.
          cnt_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          ack_s  = onehot8(owner_r);
          busy_s = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_s = ST_IDLE;
        ack_s   = 8'd0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        ack_s   = 8'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything, discarding any tenure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      owner_r   <= 3'd0;
      ack_r     <= 8'd0;
      busy_r    <= 1'b0;
      prio_r    <= 3'd0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      owner_r   <= owner_s;
      ack_r     <= ack_s;
      busy_r    <= busy_s;
      prio_r    <= prio_s;
      timeout_r <= timeout_s;
    end
  end

  assign ack          = ack_r;
  assign owner        = owner_r;
  assign busy         = busy_r;
  assign priority_out = prio_r;
  assign timeout      = timeout_r;

endmodule

// File: tb/tb_grant_dispatcher.sv
// Directed self-checking bench for grant_dispatcher, built with MAX_HOLD=4.
module tb_grant_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] grant_in = 3'd0;
  logic       grant_valid = 1'b0;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic [7:0] ack;
  logic [2:0] owner;
  logic       busy;
  logic [2:0] priority_out;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  grant_dispatcher #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .grant_in(grant_in), .grant_valid(grant_valid),
    .req(req), .done(done), .ack(ack), .owner(owner), .busy(busy),
    .priority_out(priority_out), .timeout(timeout)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_ack, input logic [2:0] e_own,
                         input logic e_busy, input logic [2:0] e_prio, input logic e_to);
    chk({tag, ".ack"}, {24'd0, ack}, {24'd0, e_ack});
    chk({tag, ".owner"}, {29'd0, owner}, {29'd0, e_own});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, ".prio"}, {29'd0, priority_out}, {29'd0, e_prio});
    chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, e_to});
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_all("reset_async", 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    step(); step();
    chk_all("reset_held", 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;

    // Basic accept of requester 3.
    grant_in = 3'd3; grant_valid = 1'b1; req = 8'h08;
    step();
    chk_all("accept3", 8'h08, 3'd3, 1'b1, 3'd0, 1'b0);
    grant_valid = 1'b0;
    // Grant inputs ignored in HOLD.
    grant_in = 3'd6; grant_valid = 1'b1; req = 8'h48;
    step();
    chk_all("hold3_ignore_grant", 8'h08, 3'd3, 1'b1, 3'd0, 1'b0);
    grant_valid = 1'b0; req = 8'h08;
    // done ends the tenure.
    done = 1'b1;
    step();
    chk_all("done3", 8'h00, 3'd3, 1'b0, 3'd4, 1'b0);
    done = 1'b0;
    // Grant offered during RELEASE is ignored.
    grant_in = 3'd7; grant_valid = 1'b1; req = 8'h80;
    step();
    chk_all("release_ignore", 8'h00, 3'd3, 1'b0, 3'd4, 1'b0);
    // Now in IDLE: same grant accepted.
    step();
    chk_all("accept7", 8'h80, 3'd7, 1'b1, 3'd4, 1'b0);
    grant_valid = 1'b0;
    // Requester 7 withdraws: priority wraps to 0.
    req = 8'h00;
    step();
    chk_all("withdraw7", 8'h00, 3'd7, 1'b0, 3'd0, 1'b0);
    step();

    // Stale grant in IDLE.
    grant_in = 3'd2; grant_valid = 1'b1; req = 8'h01;
    step();
    chk_all("stale_a", 8'h00, 3'd7, 1'b0, 3'd0, 1'b0);
    step();
    chk_all("stale_b", 8'h00, 3'd7, 1'b0, 3'd0, 1'b0);

    // Expiry: ack high for exactly 4 cycles, then a timeout pulse.
    grant_in = 3'd1; req = 8'h02;
    step();
    grant_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("expire_hold%0d", i), 8'h02, 3'd1, 1'b1, 3'd0, 1'b0);
      if (i < 3) step();
    end
    step();
    chk_all("expire_end", 8'h00, 3'd1, 1'b0, 3'd2, 1'b1);
    step();
    chk_all("expire_after", 8'h00, 3'd1, 1'b0, 3'd2, 1'b0);

    // Expiry coinciding with done: no timeout pulse.
    grant_in = 3'd4; grant_valid = 1'b1; req = 8'h10;
    step();
    grant_valid = 1'b0;
    chk_all("coin_hold0", 8'h10, 3'd4, 1'b1, 3'd2, 1'b0);
    step(); step(); step();
    chk_all("coin_hold3", 8'h10, 3'd4, 1'b1, 3'd2, 1'b0);
    done = 1'b1;
    step();
    chk_all("coin_end", 8'h00, 3'd4, 1'b0, 3'd5, 1'b0);
    done = 1'b0;
    step();

    // Reset mid-HOLD discards the tenure.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grant_in = 3'd5; grant_valid = 1'b1; req = 8'h20;
    step();
    chk_all("accept5", 8'h20, 3'd5, 1'b1, 3'd0, 1'b0);
    grant_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 chk_all("midhold_rst", 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_all("post_rst", 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/grant_dispatcher.md
GRANT_DISPATCHER -- requirements
Module: grant_dispatcher

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, giving the maximum HOLD tenure in cycles; legal range 2..256.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port grant_in, input, 3, the encoded winner index from the rotating priority encoder.
REQ-005 SHALL have port grant_valid, input, 1, high when grant_in is meaningful.
REQ-006 SHALL have port req, input, 8, the live request lines, one per requester.
REQ-007 SHALL have port done, input, 1, a pulse from the shared resource ending the current tenure.
REQ-008 SHALL have port ack, output, 8, the registered one-hot grant to the requesters.
REQ-009 SHALL have port owner, output, 3, the registered index of the current or most recent owner.
REQ-010 SHALL have port busy, output, 1, high while in HOLD.
REQ-011 SHALL have port priority_out, output, 3, the registered rotation start fed back to the encoder's priority input.
REQ-012 SHALL have port timeout, output, 1, a one-cycle pulse when a tenure is revoked by MAX_HOLD expiry.

Function
REQ-013 SHALL implement the three-state FSM IDLE, HOLD and RELEASE; all outputs are registered.
REQ-014 In IDLE, with grant_valid=1 and req[grant_in]=1: owner<=grant_in, hold counter<=0, next state HOLD; ack is one-hot of owner starting the next cycle (1-cycle latency).
REQ-015 In IDLE, with grant_valid=1 and req[grant_in]=0 (stale grant): no change; remain in IDLE.
REQ-016 In IDLE: ack=0 and busy=0.
REQ-017 In HOLD: ack=1<<owner, busy=1, and the counter increments each cycle.
REQ-018 In HOLD, grant_valid and grant_in are ignored.
REQ-019 HOLD exits to RELEASE on the first of three events:
- done=1;
- req[owner]=0 (requester withdrew);
- counter reaching MAX_HOLD-1, which pulses timeout for exactly that transition cycle.
REQ-020 If the timeout condition coincides with done or with a withdrawn request: exit normally, timeout stays 0.
REQ-021 On the HOLD-to-RELEASE transition: ack<=0, busy<=0, priority_out<=(owner+1) mod 8; owner=7 wraps priority_out to 0.
REQ-022 RELEASE lasts exactly one cycle with ack=0, then goes to IDLE unconditionally; grant_valid is ignored in RELEASE.
REQ-023 The minimum spacing between two tenures is: 1 HOLD cycle + 1 RELEASE cycle + 1 IDLE cycle before the next ack.
REQ-024 The counter width SHALL be clog2(MAX_HOLD), and the counter SHALL never wrap inside HOLD.
REQ-025 ack SHALL be one-hot or zero in every cycle; it is never multi-hot.
REQ-026 priority_out SHALL change only on the HOLD-to-RELEASE transition.
REQ-027 owner SHALL hold its value through RELEASE and IDLE until the next accepted grant.

Reset
REQ-028 While rst_n=0, immediately and independently of clk: FSM=IDLE, ack=0, owner=0, busy=0, priority_out=0, timeout=0, counter=0.
REQ-029 Reset asserted mid-HOLD SHALL drop ack in the same cycle, and the tenure SHALL be discarded with no priority_out update.
REQ-030 The first accepted grant after rst_n rises SHALL need one clk edge with rst_n=1 and grant_valid=1.

Verification
REQ-031 Reset, then grant_in=3, grant_valid=1, req=8'h08 for one cycle -> next cycle ack=8'h08, owner=3, busy=1.
REQ-032 From that HOLD, pulse done -> next cycle ack=0, busy=0, priority_out=4; one cycle later FSM is in IDLE.
REQ-033 grant_in=7 accepted, then req[7] drops -> ack=0 and priority_out=0 (wrap), timeout=0.
REQ-034 MAX_HOLD=4, req held high, no done -> ack high for 4 cycles, timeout=1 for one cycle, then ack=0 and priority_out=owner+1.
REQ-035 Stale grant: grant_in=2, grant_valid=1, req=8'h01 -> ack stays 0 and busy stays 0.
REQ-036 rst_n pulled low mid-HOLD with owner=5 -> ack=0 immediately, priority_out remains its pre-tenure value of 0.
